// File: rtl/m9k_load_sequencer.sv
// Purpose : fills one 512x16 M9K buffer from SDRAM, one outstanding word read at a time.
// Latency : start->req 1 cycle; ack->WR 1 cycle; ack->next req 2 cycles; last WR->done 2 cycles.
// Backpr. : read request is held (address stable) until the SDRAM controller acks it.
//
// Ports:
//   CLOCK_50, RESET_N            clock, asynchronous active-low reset
//   start, abort, base_addr      control: begin a load at base_addr / cancel it
//   sdram_rd_req/addr/ack/data   SDRAM read port (req held until one-cycle ack)
//   WR, wr_address_word/data     M9K buffer write port
//   busy, done, loaded, checksum status towards the datapath
// Build option: define M9K_LOAD_CHECKSUM_EN to accumulate a 16-bit sum of loaded words;
// when undefined checksum reads constant zero and no adder exists.
module m9k_load_sequencer #(
  parameter int WORDS    = 512,
  parameter int SDRAM_AW = 22
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                start,
  input  logic                abort,
  input  logic [SDRAM_AW-1:0] base_addr,
  output logic                sdram_rd_req,
  output logic [SDRAM_AW-1:0] sdram_rd_addr,
  input  logic                sdram_rd_ack,
  input  logic [15:0]         sdram_rd_data,
  output logic                WR,
  output logic [8:0]          wr_address_word,
  output logic [15:0]         wr_data_word,
  output logic                busy,
  output logic                done,
  output logic                loaded,
  output logic [15:0]         checksum
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WRITE, S_DONE} state_e;

  localparam logic [8:0] LAST_IDX = 9'(WORDS - 1);

  state_e              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [8:0]          wa_q, wa_d;
  logic [15:0]         wd_q, wd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                loaded_q, loaded_d;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    addr_d   = addr_q;
    wr_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    loaded_d = loaded_q;

    case (state_q)
      S_IDLE: begin
        // abort outranks a same-cycle start and invalidates the buffer
        if (abort) begin
          loaded_d = 1'b0;
        end else if (start) begin
          addr_d   = base_addr;
          cnt_d    = '0;
          loaded_d = 1'b0;
          busy_d   = 1'b1;
          req_d    = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        if (sdram_rd_ack) begin
          wd_d    = sdram_rd_data;
          wa_d    = cnt_q;
          wr_d    = 1'b1;
          req_d   = 1'b0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 9'd1;
          // address tracks base+counter and wraps at the SDRAM address width
          addr_d  = addr_q + SDRAM_AW'(1);
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        loaded_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort in any active state: drop everything, suppress capture/write/done.
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      req_d    = 1'b0;
      wr_d     = 1'b0;
      wa_d     = wa_q;
      wd_d     = wd_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      loaded_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
    end
  end

`ifdef M9K_LOAD_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;

  // Sum is taken in the WRITE cycle from the registered write data, so the
  // final value is complete by the time done pulses.
  always_comb begin
    csum_d = csum_q;
    if (abort)                          csum_d = '0;
    else if (state_q == S_IDLE && start) csum_d = '0;
    else if (state_q == S_WRITE)        csum_d = csum_q + wd_q;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 16'h0000;
`endif

  assign sdram_rd_req    = req_q;
  assign sdram_rd_addr   = addr_q;
  assign WR              = wr_q;
  assign wr_address_word = wa_q;
  assign wr_data_word    = wd_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign loaded          = loaded_q;

endmodule

// File: tb/tb_m9k_load_sequencer.sv
// Bench for m9k_load_sequencer: a 4-word instance driven cycle by cycle from a
// vector table, and a 512-word instance served by a small SDRAM responder.
module tb_m9k_load_sequencer;

`ifdef M9K_LOAD_CHECKSUM_EN
  localparam logic [15:0] CS_MASK = 16'hFFFF;
`else
  localparam logic [15:0] CS_MASK = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- 512-word instance ----------------
  logic        d_start = 1'b0, d_abort = 1'b0;
  logic [21:0] d_base = '0;
  logic        d_req, d_wr, d_busy, d_done, d_loaded;
  logic [21:0] d_addr;
  logic        a_ack = 1'b0;
  logic [15:0] a_data = '0;
  logic [8:0]  d_wa;
  logic [15:0] d_wd, d_cs;

  m9k_load_sequencer #(.WORDS(512), .SDRAM_AW(22)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(d_start), .abort(d_abort),
    .base_addr(d_base), .sdram_rd_req(d_req), .sdram_rd_addr(d_addr),
    .sdram_rd_ack(a_ack), .sdram_rd_data(a_data), .WR(d_wr),
    .wr_address_word(d_wa), .wr_data_word(d_wd), .busy(d_busy),
    .done(d_done), .loaded(d_loaded), .checksum(d_cs));

  // ---------------- 4-word instance ----------------
  logic        s_start = 1'b0, s_abort = 1'b0, s_ack = 1'b0;
  logic [15:0] s_rdata = '0;
  logic [21:0] s_base = 22'h3FFFFE;
  logic        s_req, s_wr, s_busy, s_done, s_loaded;
  logic [21:0] s_addr;
  logic [8:0]  s_wa;
  logic [15:0] s_wd, s_cs;

  m9k_load_sequencer #(.WORDS(4), .SDRAM_AW(22)) dut4 (
    .CLOCK_50(clk), .RESET_N(rst_n), .start(s_start), .abort(s_abort),
    .base_addr(s_base), .sdram_rd_req(s_req), .sdram_rd_addr(s_addr),
    .sdram_rd_ack(s_ack), .sdram_rd_data(s_rdata), .WR(s_wr),
    .wr_address_word(s_wa), .wr_data_word(s_wd), .busy(s_busy),
    .done(s_done), .loaded(s_loaded), .checksum(s_cs));

  // SDRAM model: acks after 'lat' full request cycles, data = address[15:0].
  int lat = 0;
  int wcnt = 0;
  always @(negedge clk) begin
    a_ack = 1'b0;
    if (d_req) begin
      if (wcnt == lat) begin
        a_ack  = 1'b1;
        a_data = d_addr[15:0];
      end
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // Write-stream monitor: expects address idx and data 0x0100+idx in order.
  logic mon_clr = 1'b0;
  int mon_wr = 0, mon_err = 0, mon_done = 0;
  always @(negedge clk) begin
    if (mon_clr) begin
      mon_wr = 0; mon_err = 0; mon_done = 0;
    end else begin
      if (d_wr) begin
        if (d_wa !== 9'(mon_wr) || d_wd !== 16'(16'h0100 + mon_wr)) mon_err++;
        mon_wr++;
      end
      if (d_done) mon_done++;
    end
  end

  typedef struct {
    logic        start, abort, ack;
    logic [15:0] rdata;
    logic        req;
    logic [21:0] addr;
    logic        wr;
    logic [8:0]  wa;
    logic [15:0] wd;
    logic        busy, done, loaded;
    logic [15:0] cs;
  } vec_t;

  function automatic vec_t mk(input logic st, ab, ak, input logic [15:0] rd,
                              input logic rq, input logic [21:0] ad, input logic w,
                              input logic [8:0] wa, input logic [15:0] wd,
                              input logic b, dn, ld, input logic [15:0] cs);
    vec_t v;
    v.start = st; v.abort = ab; v.ack = ak; v.rdata = rd;
    v.req = rq; v.addr = ad; v.wr = w; v.wa = wa; v.wd = wd;
    v.busy = b; v.done = dn; v.loaded = ld; v.cs = cs & CS_MASK;
    return v;
  endfunction

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [67:0] d_bundle();
    return {d_req, d_addr, d_wr, d_wa, d_wd, d_busy, d_done, d_loaded, d_cs};
  endfunction

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic start_load(input logic [21:0] base);
    @(negedge clk);
    d_base  = base;
    d_start = 1'b1;
  endtask

  // n = cycles from the start cycle to the cycle where done is seen.
  task automatic wait_done(input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      d_start = 1'b0;
      n++;
      if (d_done) begin ok = 1'b1; break; end
    end
  endtask

  vec_t tbl[19];

  initial begin
    int n;
    bit ok;
    bit seen;

    tbl[0]  = mk(0,0,0,16'h0000, 0,22'h000000,0,9'd0,16'h0000, 0,0,0,16'h0000);
    tbl[1]  = mk(0,0,1,16'hDEAD, 0,22'h000000,0,9'd0,16'h0000, 0,0,0,16'h0000);
    tbl[2]  = mk(1,0,0,16'h0000, 1,22'h3FFFFE,0,9'd0,16'h0000, 1,0,0,16'h0000);
    tbl[3]  = mk(1,0,0,16'h0000, 1,22'h3FFFFE,0,9'd0,16'h0000, 1,0,0,16'h0000);
    tbl[4]  = mk(0,0,1,16'h1111, 0,22'h3FFFFE,1,9'd0,16'h1111, 1,0,0,16'h0000);
    tbl[5]  = mk(1,0,1,16'hBEEF, 1,22'h3FFFFF,0,9'd0,16'h1111, 1,0,0,16'h1111);
    tbl[6]  = mk(0,0,1,16'h2222, 0,22'h3FFFFF,1,9'd1,16'h2222, 1,0,0,16'h1111);
    tbl[7]  = mk(0,0,0,16'h0000, 1,22'h000000,0,9'd1,16'h2222, 1,0,0,16'h3333);
    tbl[8]  = mk(0,0,1,16'h3333, 0,22'h000000,1,9'd2,16'h3333, 1,0,0,16'h3333);
    tbl[9]  = mk(0,0,0,16'h0000, 1,22'h000001,0,9'd2,16'h3333, 1,0,0,16'h6666);
    tbl[10] = mk(0,0,1,16'h4444, 0,22'h000001,1,9'd3,16'h4444, 1,0,0,16'h6666);
    tbl[11] = mk(0,0,0,16'h0000, 0,22'h000001,0,9'd3,16'h4444, 1,0,0,16'hAAAA);
    tbl[12] = mk(0,0,0,16'h0000, 0,22'h000001,0,9'd3,16'h4444, 0,1,1,16'hAAAA);
    tbl[13] = mk(0,0,0,16'h0000, 0,22'h000001,0,9'd3,16'h4444, 0,0,1,16'hAAAA);
    tbl[14] = mk(0,1,0,16'h0000, 0,22'h000001,0,9'd3,16'h4444, 0,0,0,16'h0000);
    tbl[15] = mk(1,1,0,16'h0000, 0,22'h000001,0,9'd3,16'h4444, 0,0,0,16'h0000);
    tbl[16] = mk(1,0,0,16'h0000, 1,22'h3FFFFE,0,9'd3,16'h4444, 1,0,0,16'h0000);
    tbl[17] = mk(0,1,1,16'h5555, 0,22'h3FFFFE,0,9'd3,16'h4444, 0,0,0,16'h0000);
    tbl[18] = mk(0,0,1,16'h6666, 0,22'h3FFFFE,0,9'd3,16'h4444, 0,0,0,16'h0000);

    repeat (3) @(negedge clk);
    check("reset_512", {28'd0, d_bundle()}, 96'd0);
    #2 rst_n = 1'b1;

    // ---- cycle-by-cycle table on the 4-word instance ----
    @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      s_start = tbl[i].start; s_abort = tbl[i].abort;
      s_ack   = tbl[i].ack;   s_rdata = tbl[i].rdata;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            {28'd0, s_req, s_addr, s_wr, s_wa, s_wd, s_busy, s_done, s_loaded, s_cs},
            {28'd0, tbl[i].req, tbl[i].addr, tbl[i].wr, tbl[i].wa, tbl[i].wd,
             tbl[i].busy, tbl[i].done, tbl[i].loaded, tbl[i].cs});
    end
    s_start = 1'b0; s_abort = 1'b0; s_ack = 1'b0;

    // ---- 512 words, ack one cycle after req ----
    clear_mon();
    lat = 1;
    start_load(22'h000100);
    wait_done(4000, n, ok);
    check("a_done_seen", 96'(ok), 96'd1);
    repeat (2) @(negedge clk);
    check("a_wr_stream_err", 96'(mon_err), 96'd0);
    check("a_wr_count", 96'(mon_wr), 96'd512);
    check("a_done_pulses", 96'(mon_done), 96'd1);
    check("a_busy_loaded", {94'd0, d_busy, d_loaded}, 96'b01);
    check("a_checksum", 96'(d_cs), 96'(16'hFF00 & CS_MASK));

    // ---- 512 words, zero-wait ----
    clear_mon();
    lat = 0;
    start_load(22'h000100);
    wait_done(1100, n, ok);
    check("b_done_latency", 96'(n), 96'd1026);
    check("b_loaded_with_done", 96'(d_loaded), 96'd1);
    repeat (2) @(negedge clk);
    check("b_wr_count", 96'(mon_wr), 96'd512);
    check("b_checksum", 96'(d_cs), 96'(16'hFF00 & CS_MASK));

    // ---- abort in the cycle word 10 is acked ----
    clear_mon();
    start_load(22'h000100);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      d_start = 1'b0;
      if (d_req && d_addr == 22'h00010A) begin seen = 1'b1; break; end
    end
    check("c_reached_word10", 96'(seen), 96'd1);
    d_abort = 1'b1;
    @(negedge clk);
    d_abort = 1'b0;
    check("c_after_abort", {28'd0, d_bundle()},
          {28'd0, 1'b0, 22'h00010A, 1'b0, 9'd9, 16'h0109, 1'b0, 1'b0, 1'b0, 16'h0000});
    repeat (6) @(negedge clk);
    check("c_writes_before_abort", 96'(mon_wr), 96'd10);
    check("c_no_done", 96'(mon_done), 96'd0);
    clear_mon();
    start_load(22'h000100);
    wait_done(1100, n, ok);
    check("c_reload_done", 96'(ok), 96'd1);
    repeat (2) @(negedge clk);
    check("c_reload_stream_err", 96'(mon_err), 96'd0);
    check("c_reload_count", 96'(mon_wr), 96'd512);
    check("c_reload_checksum", 96'(d_cs), 96'(16'hFF00 & CS_MASK));

    // ---- asynchronous reset mid-load ----
    clear_mon();
    start_load(22'h000100);
    seen = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      d_start = 1'b0;
      if (mon_wr >= 200) begin seen = 1'b1; break; end
    end
    check("d_reached_word200", 96'(seen), 96'd1);
    #2 rst_n = 1'b0;
    #1 check("d_async_reset", {28'd0, d_bundle()}, 96'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (d_req || d_wr || d_busy || d_loaded) seen = 1'b1;
    end
    check("d_idle_after_reset", 96'(seen), 96'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/m9k_load_sequencer.md
# m9k_load_sequencer

Sequences the fill of one 512×16 M9K weight/input buffer from SDRAM. On a start pulse it issues one-outstanding word reads to the SDRAM read port, writes each returned word into consecutive buffer addresses through the buffer's write port (WR / wr_address_word / wr_data_word), and then raises a level flag telling the neural-net datapath that the buffer contents are valid. It sits between the SDRAM controller and the M9K buffer; the datapath reads the buffer only while `loaded` is high.

## Interface
- WORDS, 512: number of 16-bit words loaded per start; 2..512.
- SDRAM_AW, 22: SDRAM word-address width.
- CLOCK_50  in  1  single clock, all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- abort  in  1  synchronous; cancels a load in progress.
- base_addr  in  SDRAM_AW  SDRAM word address of word 0; sampled on accepted start.
- sdram_rd_req  out  1  read request, held until ack.
- sdram_rd_addr  out  SDRAM_AW  read address, stable while req high.
- sdram_rd_ack  in  1  one-cycle pulse; sdram_rd_data valid in the same cycle.
- sdram_rd_data  in  16  read data.
- WR  out  1  buffer write strobe.
- wr_address_word  out  9  buffer word address.
- wr_data_word  out  16  buffer write data.
- busy  out  1  high from accepted start until done/abort.
- done  out  1  one-cycle pulse at end of a complete load.
- loaded  out  1  buffer holds a complete load.
- checksum  out  16  sum of loaded words (see Configuration).

## Operation
- States: IDLE, REQ, WRITE, DONE. All outputs registered.
- IDLE: start=1 → latch base_addr, word counter=0, loaded←0, busy←1, → REQ. start outside IDLE ignored.
- REQ: sdram_rd_req=1, sdram_rd_addr=base+counter. On ack: capture sdram_rd_data, req←0, → WRITE.
- WRITE: WR=1 for exactly one cycle, wr_address_word=counter, wr_data_word=captured data. If counter==WORDS-1 → DONE, else counter+1 → REQ.
- DONE: done=1 one cycle, loaded←1, busy←0, → IDLE.
- sdram_rd_addr arithmetic modulo 2^SDRAM_AW (wraps silently); buffer address never exceeds WORDS-1.
- Ack outside REQ ignored; no data captured, no write.
- abort=1 in any non-IDLE state: → IDLE next cycle, req←0, WR←0, busy←0, loaded←0, no done pulse. Abort wins over a same-cycle ack or final write. abort in IDLE: loaded←0.
- start and abort in same IDLE cycle: abort wins, no load begins.
- Reset (any time, incl. mid-load): state IDLE; sdram_rd_req, WR, busy, done, loaded = 0; sdram_rd_addr, wr_address_word, wr_data_word, checksum = 0.

## Timing
- start sampled at edge k → sdram_rd_req high after edge k (cycle k+1).
- Ack sampled at edge m → WR high in cycle m+1 → next req high in cycle m+2.
- Minimum 2 cycles per word (ack in first REQ cycle); full 512-word load with zero-wait SDRAM: 1 + 1024 cycles to DONE, done/loaded asserted 1026 cycles after start edge.
- loaded rises the same edge done rises; done falls one cycle later, loaded stays.
- Datapath read-after-load: first buffer read valid in cycle after loaded rises.

## Configuration
- M9K_LOAD_CHECKSUM_EN defined: checksum cleared on accepted start, adds wr_data_word (16-bit, wrap-around) on each WRITE cycle; final value valid when done pulses, held until next start/reset/abort (abort clears it).
- Undefined: checksum tied to 0, no adder synthesized; all other behaviour identical.

## Test plan
- Reset then start, base_addr=0x000100, WORDS=512, ack one cycle after each req, data=addr[15:0] → 512 WR pulses, addresses 0..511 with data 0x0100..0x02FF, done one pulse, loaded=1.
- Same with zero-wait ack → done exactly 1026 cycles after start edge; checksum (macro on) = 0x0100+…+0x02FF mod 2^16 = 0xFF00; macro off checksum=0.
- base_addr=0x3FFFFE, WORDS=4 → sdram_rd_addr 0x3FFFFE,0x3FFFFF,0x000000,0x000001; wr_address_word 0..3.
- abort asserted in the cycle ack for word 10 arrives → no WR for word 10, busy=0, loaded=0, no done; subsequent start reloads from word 0.
- Spurious ack in IDLE and second start while busy → no WR, no address change, load completes normally once.
- RESET_N low mid-load (word 200) asynchronously → req, WR, busy, loaded drop immediately; after release, module idle until start.
